// File: rtl/vga_pkg.sv
// Shared constants and state type for the VGA rectangle fill master.
// Optional ack timeout is enabled with VGA_FILL_TIMEOUT_EN.
package vga_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam logic [31:0] VRAM_BASE = 32'h0000_0000;
  localparam int TIMEOUT = 16;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam int CW = 10;
  localparam int XW = 11;
  localparam int AW = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/vga_fill_addr_gen.sv
// Raster walker: clipped bounds, x/y counters and running pixel address.
// Timeout option (VGA_FILL_TIMEOUT_EN) lives in the top; none here.
module vga_fill_addr_gen
  import vga_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter logic [AW-1:0] BASE = VRAM_BASE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          adv,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] w,
  input  logic [CW-1:0] h,
  output logic          empty,
  output logic          last,
  output logic [AW-1:0] adr
);

  localparam logic [XW-1:0] HX = XW'(H_RES);
  localparam logic [XW-1:0] VX = XW'(V_RES);

  logic [XW-1:0] x_sum;
  logic [XW-1:0] y_sum;
  logic [XW-1:0] x_lim;
  logic [XW-1:0] y_lim;
  logic [XW-1:0] x_q;
  logic [XW-1:0] y_q;
  logic [XW-1:0] xs_q;
  logic [XW-1:0] xe_q;
  logic [XW-1:0] ye_q;
  logic [AW-1:0] row_adr;
  logic [AW-1:0] wrap_adr;
  logic          row_end;

  assign x_sum = {1'b0, x0} + {1'b0, w};
  assign y_sum = {1'b0, y0} + {1'b0, h};
  assign x_lim = (x_sum > HX) ? HX : x_sum;
  assign y_lim = (y_sum > VX) ? VX : y_sum;

  assign empty = (w == '0) || (h == '0) ||
                 ({1'b0, x0} >= HX) ||
                 ({1'b0, y0} >= VX);

  assign row_end = (x_q == xe_q - XW'(1));
  assign last = row_end && (y_q == ye_q - XW'(1));

  assign row_adr = BASE + AW'(y0) * AW'(H_RES) + AW'(x0);

  // From last pixel of a row back to x0 on the next line.
  assign wrap_adr = adr + AW'(H_RES) + AW'(xs_q)
                  - AW'(xe_q) + AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      xs_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
      adr  <= '0;
    end else if (load) begin
      x_q  <= {1'b0, x0};
      y_q  <= {1'b0, y0};
      xs_q <= {1'b0, x0};
      xe_q <= x_lim;
      ye_q <= y_lim;
      adr  <= row_adr;
    end else if (adv) begin
      if (row_end) begin
        x_q <= xs_q;
        y_q <= y_q + XW'(1);
        adr <= wrap_adr;
      end else begin
        x_q <= x_q + XW'(1);
        adr <= adr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_fill_master.sv
// Wishbone master filling a framebuffer rectangle with one palette index.
// Define VGA_FILL_TIMEOUT_EN to abort a beat whose ack never arrives.
module vga_fill_master
  import vga_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          start_i,
  input  logic [9:0]    x0_i,
  input  logic [9:0]    y0_i,
  input  logic [9:0]    w_i,
  input  logic [9:0]    h_i,
  input  logic [7:0]    color_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [31:0]   wb_adr_o,
  output logic [3:0]    wb_sel_o,
  output logic [31:0]   wb_dat_o,
  input  logic          wb_ack_i,
  input  logic [31:0]   wb_dat_i
);

  state_t state;
  logic   empty;
  logic   last;
  logic   load;
  logic   adv;
  logic   unused_dat;

  assign unused_dat = ^wb_dat_i;
  assign wb_sel_o = 4'b0001;
  assign load = (state == IDLE) && start_i;
  assign adv = (state == GAP);

`ifdef VGA_FILL_TIMEOUT_EN
  logic [TW-1:0] tcnt;
  logic          err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  vga_fill_addr_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .BASE  (VRAM_BASE)
  ) u_addr (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .load  (load),
    .adv   (adv),
    .x0    (x0_i),
    .y0    (y0_i),
    .w     (w_i),
    .h     (h_i),
    .empty (empty),
    .last  (last),
    .adr   (wb_adr_o)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state    <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_dat_o <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
`ifdef VGA_FILL_TIMEOUT_EN
      tcnt     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            wb_dat_o <= {24'b0, color_i};
`ifdef VGA_FILL_TIMEOUT_EN
            err_q <= 1'b0;
            tcnt  <= '0;
`endif
            if (empty) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state    <= REQ;
              busy_o   <= 1'b1;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (wb_ack_i) begin
            state    <= GAP;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
          end
`ifdef VGA_FILL_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            state    <= DONE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            err_q    <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        GAP: begin
          // Bus idle this cycle so a registered ack can fall.
          if (last) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state    <= REQ;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
`ifdef VGA_FILL_TIMEOUT_EN
            tcnt <= '0;
`endif
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vga_fill_master.md
# vga_fill_master

Wishbone master that fills a rectangle of the VGA framebuffer with one 8-bit palette index. It sits beside the CPU on the system Wishbone bus and issues single-beat classic write cycles into the VRAM window of the VGA peripheral, offloading block clears and fills from software. Rectangle parameters arrive on a simple start/done port from a control register block.

## Interface
- H_RES, 640, pixels per line; pixel address stride
- V_RES, 480, lines per frame
- VRAM_BASE, 32'h0000_0000, bus address of pixel (0,0); pixel (x,y) is at VRAM_BASE + y*H_RES + x
- TIMEOUT, 16, max cycles to wait for ack per beat (used only with the timeout feature)

- wb_clk_i  in  1  single clock
- wb_rst_n_i  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle request; sampled only in IDLE
- x0_i, y0_i  in  10 each  top-left corner
- w_i, h_i  in  10 each  width/height in pixels
- color_i  in  8  palette index to write
- busy_o  out  1  high from the cycle after accepted start until done
- done_o  out  1  one-cycle pulse at completion or abort
- err_o  out  1  sticky abort flag, cleared by next accepted start
- wb_cyc_o, wb_stb_o  out  1 each  bus request
- wb_we_o  out  1  high whenever stb is high
- wb_adr_o  out  32  pixel address
- wb_sel_o  out  4  constant 4'b0001
- wb_dat_o  out  32  {24'b0, color}
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  32  unused (write-only master)

## Operation
- States: IDLE, REQ, GAP, DONE.
- IDLE: on start_i, latch color; clip: x_end = min(x0+w, H_RES), y_end = min(y0+h, V_RES) (11-bit compare). If w==0, h==0, x0>=H_RES or y0>=V_RES: go to DONE, no bus cycle. Else load row start address VRAM_BASE + y0*H_RES + x0 (one multiply at start, or shift-add), go to REQ.
- REQ: cyc=stb=we=1, adr = current pixel. Hold all bus outputs stable until ack_i. On ack go to GAP.
- GAP: cyc=stb=0 for exactly one cycle; ack_i ignored. Advance: x+1, adr+1; at x==x_end-1 wrap x to x0, y+1, adr += H_RES - (x_end - x0) + 1. If last pixel (x==x_end-1, y==y_end-1) go to DONE, else REQ.
- DONE: done_o=1 for one cycle, busy_o=0, return to IDLE.
- start_i while not IDLE: ignored, no queueing.
- Pixel order raster: left to right, top to bottom.
- Reset outputs: cyc/stb/we=0, adr=0, dat=0, busy=0, done=0, err=0, state IDLE.
- Reset mid-operation: bus request dropped on that edge, no done pulse, remaining pixels discarded.

## Timing
- Start accepted at edge N; busy_o and first stb high from cycle N+1.
- Per pixel with a slave that acks one cycle after stb: REQ (ack low), REQ (ack high), GAP = 3 cycles. The mandatory GAP guarantees the slave's registered ack deasserts before the next strobe, so one ack is never applied to two addresses.
- w*h pixels (after clipping): done_o in cycle N+1+3*w*h; one-cycle extra for zero-size: done_o at N+1.
- ack_i arriving while stb low: ignored.

## Configuration
- VGA_FILL_TIMEOUT_EN defined: counter starts at each REQ entry; if ack not seen within TIMEOUT cycles, drop cyc/stb, set err_o, go to DONE (done_o pulses). Remaining pixels not written.
- Undefined: REQ waits indefinitely; err_o tied 0; no counter logic.

## Structure
- Package vga_pkg: H_RES/V_RES defaults, VRAM_BASE, state enum (IDLE, REQ, GAP, DONE), pixel/coordinate width constants.
- Sub-module vga_fill_addr_gen: x/y counters, clip bounds, running address, last-pixel flag; FSM in top.

## Test plan
- x0=10,y0=2,w=3,h=2,color=8'h5A, 1-cycle-ack slave -> writes to 1290,1291,1292,1930,1931,1932 in order, dat 32'h5A, done_o at start+19, busy low after.
- w=0,h=5 -> done_o one cycle after start, cyc_o never asserted, err_o=0.
- x0=638,y0=479,w=4,h=4 -> clipped to 2 pixels: 307198, 307199 only.
- Slave with 4-cycle ack latency on 1x1 fill -> stb/adr stable through wait, single write, done after ack+GAP.
- Reset pulsed low during 3rd beat of a 4x1 fill -> cyc/stb low next cycle, no done_o, busy_o 0; start_i during busy ignored.
- VGA_FILL_TIMEOUT_EN with TIMEOUT=16, slave never acks -> stb drops after 16 cycles, err_o=1, done_o pulse; next start clears err_o.
